// File: rtl/vga_scan_gen_if.sv
// Scan-address bundle from vga_scan_gen to hit-test consumers.
// Master drives the raster position, sync and frame timing.
interface vga_scan_gen_if;
  logic        pix_en;
  logic [9:0]  addr_x;
  logic [9:0]  addr_y;
  logic        active;
  logic        hsync_n;
  logic        vsync_n;
  logic        line_start;
  logic        frame_start;
  logic [15:0] frame_count;

  modport master (
    output pix_en, addr_x, addr_y, active,
    output hsync_n, vsync_n,
    output line_start, frame_start, frame_count
  );

  modport slave (
    input pix_en, addr_x, addr_y, active,
    input hsync_n, vsync_n,
    input line_start, frame_start, frame_count
  );
endinterface

// File: rtl/vga_scan_gen.sv
// Raster scan generator: pixel address stream, VGA sync/blank,
// line/frame pulses and a wrapping frame counter.
module vga_scan_gen #(
  parameter int PIX_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic         clock,
  input  logic         resetn,
  vga_scan_gen_if.master scan
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [2:0] DIV_LAST = 3'(PIX_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [2:0]  div_q, div_d;
  logic        pix_en_q, pix_en_d;
  logic [9:0]  h_q, h_d;
  logic [9:0]  v_q, v_d;
  logic        active_q, active_d;
  logic        hsync_n_q, hsync_n_d;
  logic        vsync_n_q, vsync_n_d;
  logic        line_q, line_d;
  logic        frame_q, frame_d;
  logic [15:0] fcnt_q, fcnt_d;

  logic tick;
  logic h_wrap;
  logic v_wrap;

  // Divider, counter advance and registered output decode.
  always_comb begin
    tick      = (div_q == DIV_LAST);
    h_wrap    = (h_q == H_LAST);
    v_wrap    = (v_q == V_LAST);
    div_d     = tick ? 3'd0 : div_q + 3'd1;
    pix_en_d  = tick;
    h_d       = h_q;
    v_d       = v_q;
    active_d  = active_q;
    hsync_n_d = hsync_n_q;
    vsync_n_d = vsync_n_q;
    line_d    = 1'b0;
    frame_d   = 1'b0;
    fcnt_d    = fcnt_q;
    if (tick) begin
      h_d = h_wrap ? 10'd0 : h_q + 10'd1;
      if (h_wrap) begin
        v_d = v_wrap ? 10'd0 : v_q + 10'd1;
      end
      line_d  = h_wrap;
      frame_d = h_wrap && v_wrap;
      if (h_wrap && v_wrap) begin
        fcnt_d = fcnt_q + 16'd1;
      end
      active_d  = (h_d < H_VIS) && (v_d < V_VIS);
      hsync_n_d = !((h_d >= HS_BEG) && (h_d < HS_END));
      vsync_n_d = !((v_d >= VS_BEG) && (v_d < VS_END));
    end
  end

  // State and output registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      div_q     <= '0;
      pix_en_q  <= 1'b0;
      h_q       <= '0;
      v_q       <= '0;
      active_q  <= 1'b0;
      hsync_n_q <= 1'b1;
      vsync_n_q <= 1'b1;
      line_q    <= 1'b0;
      frame_q   <= 1'b0;
      fcnt_q    <= '0;
    end else begin
      div_q     <= div_d;
      pix_en_q  <= pix_en_d;
      h_q       <= h_d;
      v_q       <= v_d;
      active_q  <= active_d;
      hsync_n_q <= hsync_n_d;
      vsync_n_q <= vsync_n_d;
      line_q    <= line_d;
      frame_q   <= frame_d;
      fcnt_q    <= fcnt_d;
    end
  end

  assign scan.pix_en      = pix_en_q;
  assign scan.addr_x      = h_q;
  assign scan.addr_y      = v_q;
  assign scan.active      = active_q;
  assign scan.hsync_n     = hsync_n_q;
  assign scan.vsync_n     = vsync_n_q;
  assign scan.line_start  = line_q;
  assign scan.frame_start = frame_q;
  assign scan.frame_count = fcnt_q;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Bench for vga_scan_gen: small-geometry main instance plus a
// one-pixel-frame instance to reach the frame counter wrap.
module tb_vga_scan_gen;

  logic clk = 1'b0;
  logic rst_n;
  logic rst2_n;
  int   k;
  int   k2;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  vga_scan_gen_if m_if ();
  vga_scan_gen_if w_if ();

  vga_scan_gen #(
    .PIX_DIV(2),
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(8),  .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) u_main (
    .clock(clk), .resetn(rst_n), .scan(m_if)
  );

  vga_scan_gen #(
    .PIX_DIV(1),
    .H_ACTIVE(1), .H_FP(0), .H_SYNC(0), .H_BP(0),
    .V_ACTIVE(1), .V_FP(0), .V_SYNC(0), .V_BP(0)
  ) u_wrap (
    .clock(clk), .resetn(rst2_n), .scan(w_if)
  );

  // Clock edges seen since the last reset release.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) k <= 0;
    else k <= k + 1;

  always @(posedge clk or negedge rst2_n)
    if (!rst2_n) k2 <= 0;
    else k2 <= k2 + 1;

  // Expected outputs after k edges, derived from pixel index arithmetic.
  function automatic logic [41:0] model(
    input int kk, input int p,
    input int ha, input int hf, input int hs, input int hb,
    input int va, input int vf, input int vs, input int vb);
    int ht, vt, n, pos, x, y;
    logic pe, ac, hsn, vsn, ls, fs;
    logic [15:0] fc;
    ht  = ha + hf + hs + hb;
    vt  = va + vf + vs + vb;
    n   = kk / p;
    pe  = (kk > 0) && (kk % p == 0);
    pos = n % (ht * vt);
    x   = pos % ht;
    y   = pos / ht;
    if (n == 0) begin
      ac  = 1'b0;
      hsn = 1'b1;
      vsn = 1'b1;
    end else begin
      ac  = (x < ha) && (y < va);
      hsn = !((x >= ha + hf) && (x < ha + hf + hs));
      vsn = !((y >= va + vf) && (y < va + vf + vs));
    end
    ls = pe && (x == 0);
    fs = pe && (pos == 0);
    fc = 16'((n / (ht * vt)) % 65536);
    return {pe, 10'(x), 10'(y), ac, hsn, vsn, ls, fs, fc};
  endfunction

  function automatic logic [41:0] pack_m();
    return {m_if.pix_en, m_if.addr_x, m_if.addr_y, m_if.active,
            m_if.hsync_n, m_if.vsync_n, m_if.line_start,
            m_if.frame_start, m_if.frame_count};
  endfunction

  function automatic logic [41:0] pack_w();
    return {w_if.pix_en, w_if.addr_x, w_if.addr_y, w_if.active,
            w_if.hsync_n, w_if.vsync_n, w_if.line_start,
            w_if.frame_start, w_if.frame_count};
  endfunction

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    logic [41:0] em, ew, am, aw;
    em = model(k, 2, 16, 2, 4, 3, 8, 2, 2, 3);
    ew = model(k2, 1, 1, 0, 0, 0, 1, 0, 0, 0);
    am = pack_m();
    aw = pack_w();
    n_cmp = n_cmp + 2;
    if (am !== em) begin
      n_bad = n_bad + 1;
      if (n_bad < 20)
        $display("FAIL main_cycle k=%0d got=%h exp=%h", k, am, em);
    end
    if (aw !== ew) begin
      n_bad = n_bad + 1;
      if (n_bad < 20)
        $display("FAIL wrap_cycle k=%0d got=%h exp=%h", k2, aw, ew);
    end
  end

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic wait_k(input bit w, input int t);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 80000; i++) begin
      @(negedge clk);
      if ((w ? k2 : k) == t) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) begin
      n_bad = n_bad + 1;
      $display("FAIL wait_k target=%0d got=%0d exp=%0d", t,
               (w ? k2 : k), t);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pix_en"}, 32'(m_if.pix_en), 32'd0);
    chk({tag, "_addr_x"}, 32'(m_if.addr_x), 32'd0);
    chk({tag, "_addr_y"}, 32'(m_if.addr_y), 32'd0);
    chk({tag, "_active"}, 32'(m_if.active), 32'd0);
    chk({tag, "_hsync"}, 32'(m_if.hsync_n), 32'd1);
    chk({tag, "_vsync"}, 32'(m_if.vsync_n), 32'd1);
    chk({tag, "_lstart"}, 32'(m_if.line_start), 32'd0);
    chk({tag, "_fstart"}, 32'(m_if.frame_start), 32'd0);
    chk({tag, "_fcount"}, 32'(m_if.frame_count), 32'd0);
  endtask

  initial begin
    rst_n  = 1'b0;
    rst2_n = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    chk_reset_vals("por");
    rst_n  = 1'b1;
    rst2_n = 1'b1;

    for (int r = 0; r < 3; r++) begin
      repeat ($urandom_range(20, 1500)) @(posedge clk);
      #($urandom_range(1, 4));
      rst_n = 1'b0;
      #1;
      chk_reset_vals("midrst");
      repeat ($urandom_range(1, 4)) @(posedge clk);
      #3;
      rst_n = 1'b1;
    end

    wait_k(1'b0, 1);
    chk("first_edge_pix_en", 32'(m_if.pix_en), 32'd0);
    wait_k(1'b0, 2);
    chk("second_edge_pix_en", 32'(m_if.pix_en), 32'd1);
    chk("second_edge_x", 32'(m_if.addr_x), 32'd1);
    chk("no_reset_lstart", 32'(m_if.line_start), 32'd0);
    wait_k(1'b0, 3);
    chk("hold_pix_en", 32'(m_if.pix_en), 32'd0);
    chk("hold_x", 32'(m_if.addr_x), 32'd1);
    wait_k(1'b0, 34);
    chk("x17_hsync", 32'(m_if.hsync_n), 32'd1);
    wait_k(1'b0, 36);
    chk("x18_x", 32'(m_if.addr_x), 32'd18);
    chk("x18_hsync", 32'(m_if.hsync_n), 32'd0);
    wait_k(1'b0, 44);
    chk("x22_hsync", 32'(m_if.hsync_n), 32'd1);
    wait_k(1'b0, 50);
    chk("line1_x", 32'(m_if.addr_x), 32'd0);
    chk("line1_y", 32'(m_if.addr_y), 32'd1);
    chk("line1_lstart", 32'(m_if.line_start), 32'd1);
    chk("line1_fstart", 32'(m_if.frame_start), 32'd0);
    wait_k(1'b0, 51);
    chk("line1_lstart_off", 32'(m_if.line_start), 32'd0);
    wait_k(1'b0, 500);
    chk("y10_y", 32'(m_if.addr_y), 32'd10);
    chk("y10_vsync", 32'(m_if.vsync_n), 32'd0);
    chk("y10_active", 32'(m_if.active), 32'd0);
    wait_k(1'b0, 750);
    chk("frame_fstart", 32'(m_if.frame_start), 32'd1);
    chk("frame_lstart", 32'(m_if.line_start), 32'd1);
    chk("frame_fcount", 32'(m_if.frame_count), 32'd1);
    chk("frame_active", 32'(m_if.active), 32'd1);
    wait_k(1'b0, 752);
    chk("frame_fstart_off", 32'(m_if.frame_start), 32'd0);

    wait_k(1'b1, 65535);
    chk("wrap_ffff", 32'(w_if.frame_count), 32'hffff);
    wait_k(1'b1, 65536);
    chk("wrap_zero", 32'(w_if.frame_count), 32'd0);
    chk("wrap_fstart", 32'(w_if.frame_start), 32'd1);
    chk("wrap_lstart", 32'(w_if.line_start), 32'd1);
    chk("wrap_pix_en", 32'(w_if.pix_en), 32'd1);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
